// File: rtl/if_instr_queue.sv
// rtl/if_instr_queue.sv - fetch-to-ID instruction queue (FIFO of fetched entries)
// Optional same-cycle IF-to-ID bypass on an empty queue: define IQ_BYPASS_EN.
module if_instr_queue #(
  parameter int DEPTH  = 8,
  parameter int EXC_W  = 8,
  parameter int PRED_W = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IQ_Flush,
  input  logic                   IF_Valid,
  input  logic [31:0]            IF_Instr,
  input  logic [31:0]            IF_PC,
  input  logic [EXC_W-1:0]       IF_ExceptType,
  input  logic [PRED_W-1:0]      IF_PResult,
  output logic                   IQ_Ready,
  input  logic                   ID_Wr,
  output logic                   IQ_Valid,
  output logic [31:0]            IQ_Instr,
  output logic [31:0]            IQ_PC,
  output logic [EXC_W-1:0]       IQ_ExceptType,
  output logic [PRED_W-1:0]      IQ_PResult,
  output logic [$clog2(DEPTH):0] IQ_Count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      rd_idx;

  logic [31:0]        instr_mem [DEPTH];
  logic [31:0]        pc_mem    [DEPTH];
  logic [EXC_W-1:0]   exc_mem   [DEPTH];
  logic [PRED_W-1:0]  pred_mem  [DEPTH];

  logic empty;
  logic full;
  logic q_valid;
  logic bypass_hit;
  logic bypass_take;
  logic enq;
  logic deq;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign q_valid = !empty;

  // Ready depends only on pointer state, never on ID_Wr.
  assign IQ_Ready = !full;
  assign IQ_Count = wr_ptr - rd_ptr;

`ifdef IQ_BYPASS_EN
  assign bypass_hit  = empty && IF_Valid && !IQ_Flush;
  assign bypass_take = bypass_hit && ID_Wr;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A bypassed entry already consumed by ID must not also be stored.
  assign enq = IF_Valid && IQ_Ready && !IQ_Flush && !bypass_take;
  assign deq = ID_Wr && q_valid && !IQ_Flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (IQ_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry RAM is never cleared; validity comes only from the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_idx] <= IF_Instr;
      pc_mem[wr_idx]    <= IF_PC;
      exc_mem[wr_idx]   <= IF_ExceptType;
      pred_mem[wr_idx]  <= IF_PResult;
    end
  end

  // Invalid head reads as an all-zero bubble (NOP).
  always_comb begin
    IQ_Valid      = 1'b0;
    IQ_Instr      = '0;
    IQ_PC         = '0;
    IQ_ExceptType = '0;
    IQ_PResult    = '0;
    if (bypass_hit) begin
      IQ_Valid      = 1'b1;
      IQ_Instr      = IF_Instr;
      IQ_PC         = IF_PC;
      IQ_ExceptType = IF_ExceptType;
      IQ_PResult    = IF_PResult;
    end else if (q_valid) begin
      IQ_Valid      = 1'b1;
      IQ_Instr      = instr_mem[rd_idx];
      IQ_PC         = pc_mem[rd_idx];
      IQ_ExceptType = exc_mem[rd_idx];
      IQ_PResult    = pred_mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_if_instr_queue.sv
// tb/tb_if_instr_queue.sv - table-driven self-checking bench for if_instr_queue
// Honors IQ_BYPASS_EN when the design is built with it.
module tb_if_instr_queue;

  localparam int DEPTH  = 8;
  localparam int EXC_W  = 8;
  localparam int PRED_W = 34;

  logic              clk = 1'b0;
  logic              rst;
  logic              IQ_Flush;
  logic              IF_Valid;
  logic [31:0]       IF_Instr;
  logic [31:0]       IF_PC;
  logic [EXC_W-1:0]  IF_ExceptType;
  logic [PRED_W-1:0] IF_PResult;
  logic              IQ_Ready;
  logic              ID_Wr;
  logic              IQ_Valid;
  logic [31:0]       IQ_Instr;
  logic [31:0]       IQ_PC;
  logic [EXC_W-1:0]  IQ_ExceptType;
  logic [PRED_W-1:0] IQ_PResult;
  logic [3:0]        IQ_Count;

  if_instr_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W), .PRED_W(PRED_W)) dut (
    .clk(clk), .rst(rst), .IQ_Flush(IQ_Flush),
    .IF_Valid(IF_Valid), .IF_Instr(IF_Instr), .IF_PC(IF_PC),
    .IF_ExceptType(IF_ExceptType), .IF_PResult(IF_PResult),
    .IQ_Ready(IQ_Ready), .ID_Wr(ID_Wr), .IQ_Valid(IQ_Valid),
    .IQ_Instr(IQ_Instr), .IQ_PC(IQ_PC), .IQ_ExceptType(IQ_ExceptType),
    .IQ_PResult(IQ_PResult), .IQ_Count(IQ_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          flush;
    bit          ifv;
    logic [31:0] pc;
    bit          idw;
    bit          ev;
    bit          er;
    int          ec;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return ~pc;
  endfunction
  function automatic logic [EXC_W-1:0] mk_exc(input logic [31:0] pc);
    return pc[9:2];
  endfunction
  function automatic logic [PRED_W-1:0] mk_pred(input logic [31:0] pc);
    return {2'b10, pc + 32'h40};
  endfunction

  // Expected values describe the outputs seen before this vector's clock edge.
  task automatic add(input bit flush, input bit ifv, input logic [31:0] pc, input bit idw,
                     input bit ev, input bit er, input int ec, input logic [31:0] epc);
    vec_t v;
    v.flush = flush; v.ifv = ifv; v.pc = pc; v.idw = idw;
    v.ev = ev; v.er = er; v.ec = ec; v.epc = epc;
`ifdef IQ_BYPASS_EN
    if (!ev && ifv && !flush) begin
      v.ev  = 1'b1;
      v.epc = pc;
    end
`endif
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit ev, input bit er, input int ec,
                         input logic [31:0] epc);
    chk({tag, ".valid"}, 64'(IQ_Valid), 64'(ev));
    chk({tag, ".ready"}, 64'(IQ_Ready), 64'(er));
    chk({tag, ".count"}, 64'(IQ_Count), 64'(ec));
    chk({tag, ".pc"},    64'(IQ_PC),    ev ? 64'(epc) : 64'h0);
    chk({tag, ".instr"}, 64'(IQ_Instr), ev ? 64'(mk_instr(epc)) : 64'h0);
    chk({tag, ".exc"},   64'(IQ_ExceptType), ev ? 64'(mk_exc(epc)) : 64'h0);
    chk({tag, ".pred"},  64'(IQ_PResult),    ev ? 64'(mk_pred(epc)) : 64'h0);
  endtask

  task automatic drive(input bit flush, input bit ifv, input logic [31:0] pc, input bit idw);
    IQ_Flush      = flush;
    IF_Valid      = ifv;
    IF_PC         = pc;
    IF_Instr      = mk_instr(pc);
    IF_ExceptType = mk_exc(pc);
    IF_PResult    = mk_pred(pc);
    ID_Wr         = idw;
  endtask

  initial begin
    // fill to full, then a dequeue while full blocks the enqueue
    for (int i = 0; i < DEPTH; i++)
      add(0, 1, 32'hBFC0_0000 + 32'(4*i), 0, i != 0, 1, i, 32'hBFC0_0000);
    add(0, 1, 32'hBFC0_0020, 1, 1, 0, 8, 32'hBFC0_0000);
    add(0, 0, 32'h0, 0, 1, 1, 7, 32'hBFC0_0004);
    // 40 cycles of streaming, head advances by 4 each cycle
    for (int j = 0; j < 40; j++)
      add(0, 1, 32'hBFC0_0020 + 32'(4*j), 1, 1, 1, 7, 32'hBFC0_0004 + 32'(4*j));
    add(1, 0, 32'h0, 0, 1, 1, 7, 32'hBFC0_00A4);
    // fill 5, flush with concurrent enqueue and dequeue
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'h1000 + 32'(4*i), 0, i != 0, 1, i, 32'h1000);
    add(1, 1, 32'h2000, 1, 1, 1, 5, 32'h1000);
    add(0, 1, 32'h3000, 0, 0, 1, 0, 32'h0);
    add(0, 0, 32'h0, 1, 1, 1, 1, 32'h3000);
    add(0, 0, 32'h0, 1, 0, 1, 0, 32'h0);
    // empty queue with fetch and ID both active
`ifdef IQ_BYPASS_EN
    add(0, 1, 32'h8000_0000, 1, 1, 1, 0, 32'h8000_0000);
    add(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
`else
    add(0, 1, 32'h8000_0000, 1, 0, 1, 0, 32'h0);
    add(0, 0, 32'h0, 0, 1, 1, 1, 32'h8000_0000);
`endif

    rst = 1'b1;
    drive(0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 1, 0, 32'h0);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].flush, vecs[k].ifv, vecs[k].pc, vecs[k].idw);
      #1;
      chk_all($sformatf("vec%0d", k), vecs[k].ev, vecs[k].er, vecs[k].ec, vecs[k].epc);
    end

    // asynchronous reset with 3 held entries and ID_Wr active
    @(negedge clk);
    drive(1, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 1, 32'h4000 + 32'(4*i), 0);
    end
    @(negedge clk);
    drive(0, 0, 32'h0, 1);
    #1;
    chk_all("pre_rst", 1, 1, 3, 32'h4000);
    #1;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 1, 0, 32'h0);
    @(negedge clk);
    chk_all("rst_hold", 0, 1, 0, 32'h0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
